// File: rtl/nes_joypad_port.sv
// rtl/nes_joypad_port.sv - 2A03 controller port responder for $4016/$4017
//
// Purpose:
//   Answers CPU bus accesses to the controller registers. A write to $4016
//   updates the OUT[2:0] latch; a read of $4016/$4017 samples that port's
//   serial data line, returns it one cycle later, and fires a clock pulse to
//   the controller so its shift register advances.
//
// Optional feature macro: JOYPAD_EXP_BITS_EN
//   Defined   : adds joyExp1/joyExp2 inputs, returned inverted in dataOut[4:3].
//   Undefined : no expansion inputs, dataOut[4:3] read 0.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   addr[15:0]   in   CPU address
//   dataIn[7:0]  in   CPU write data
//   rw           in   1 = read, 0 = write
//   cpuValid     in   one-cycle strobe per CPU access
//   dataOut[7:0] out  registered read data (holds between reads)
//   dataOutValid out  one-cycle flag when dataOut carries a read response
//   joyHit       out  combinational decode hit for the top-level read mux
//   joyOut[2:0]  out  OUT2..OUT0 latch, joyOut[0] is the controller strobe
//   joyClk1      out  port 1 clock pulse, active-high
//   joyClk2      out  port 2 clock pulse, active-high
//   joyData1     in   port 1 serial data, active-low
//   joyData2     in   port 2 serial data, active-low
//   joyExp1[1:0] in   port 1 expansion bits, active-low (macro only)
//   joyExp2[1:0] in   port 2 expansion bits, active-low (macro only)

// Per-port clock pulse generator.
//   clock    in   system clock
//   reset    in   synchronous active-high reset
//   trigger  in   read hit for this port
//   joy_clk  out  registered controller clock pulse
module nes_joypad_pulse #(
    parameter int unsigned PULSE_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic trigger,
    output logic joy_clk
);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    // The counter holds the remaining high cycles after the current one.
    localparam logic [3:0] LOAD = 4'(PULSE_CYCLES - 1);

    state_t     state;
    logic [3:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            count   <= 4'd0;
            joy_clk <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state   <= PULSE;
                        count   <= LOAD;
                        joy_clk <= 1'b1;
                    end
                end
                PULSE: begin
                    // A repeat read only stretches the pulse; the line never
                    // drops, so the controller sees a single rising edge.
                    if (trigger) begin
                        count <= LOAD;
                    end else if (count == 4'd0) begin
                        state   <= IDLE;
                        joy_clk <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    count   <= 4'd0;
                    joy_clk <= 1'b0;
                end
            endcase
        end
    end

endmodule

module nes_joypad_port #(
    parameter int unsigned CLK_PULSE_CYCLES = 2,
    parameter logic [7:0]  OPEN_BUS_VALUE   = 8'h40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  dataIn,
    input  logic        rw,
    input  logic        cpuValid,
    output logic [7:0]  dataOut,
    output logic        dataOutValid,
    output logic        joyHit,
    output logic [2:0]  joyOut,
    output logic        joyClk1,
    output logic        joyClk2,
    input  logic        joyData1,
    input  logic        joyData2
`ifdef JOYPAD_EXP_BITS_EN
    ,
    input  logic [1:0]  joyExp1,
    input  logic [1:0]  joyExp2
`endif
);

    localparam logic [15:0] ADDR_PORT1 = 16'h4016;
    localparam logic [15:0] ADDR_PORT2 = 16'h4017;

    logic is_port1;
    logic is_port2;
    logic read_port1;
    logic read_port2;
    logic write_out;
    logic serial_bit;
    logic [1:0] exp_bits;

    assign is_port1 = (addr == ADDR_PORT1);
    assign is_port2 = (addr == ADDR_PORT2);

    // Writes to $4017 belong to the APU frame counter, so only reads decode.
    assign read_port1 = cpuValid & rw & is_port1;
    assign read_port2 = cpuValid & rw & is_port2;
    assign write_out  = cpuValid & ~rw & is_port1;
    assign joyHit     = cpuValid & (is_port1 | (rw & is_port2));

    // Controller lines are active-low; software expects 1 = pressed.
    assign serial_bit = read_port1 ? ~joyData1 : ~joyData2;

`ifdef JOYPAD_EXP_BITS_EN
    assign exp_bits = read_port1 ? ~joyExp1 : ~joyExp2;
`else
    assign exp_bits = 2'b00;
`endif

    // OUT latch bits above OUT2 do not exist on the 2A03.
    logic unused_data_high;
    assign unused_data_high = ^dataIn[7:3];

    always_ff @(posedge clock) begin
        if (reset) begin
            dataOut      <= OPEN_BUS_VALUE;
            dataOutValid <= 1'b0;
            joyOut       <= 3'b000;
        end else begin
            dataOutValid <= read_port1 | read_port2;
            if (read_port1 | read_port2) begin
                // Bits 7:5 float on the real bus and keep the open-bus value.
                dataOut <= {OPEN_BUS_VALUE[7:5], exp_bits, 2'b00, serial_bit};
            end
            if (write_out) begin
                joyOut <= dataIn[2:0];
            end
        end
    end

    nes_joypad_pulse #(
        .PULSE_CYCLES(CLK_PULSE_CYCLES)
    ) u_pulse1 (
        .clock   (clock),
        .reset   (reset),
        .trigger (read_port1),
        .joy_clk (joyClk1)
    );

    nes_joypad_pulse #(
        .PULSE_CYCLES(CLK_PULSE_CYCLES)
    ) u_pulse2 (
        .clock   (clock),
        .reset   (reset),
        .trigger (read_port2),
        .joy_clk (joyClk2)
    );

endmodule

// File: tb/tb_nes_joypad_port.sv
// tb/tb_nes_joypad_port.sv - bench for nes_joypad_port (pulse widths 2 and 4)
module tb_nes_joypad_port;

    localparam logic [7:0] OPEN = 8'h40;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]  rst;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        rw;
    logic        cv;
    logic        jd1;
    logic        jd2;
`ifdef JOYPAD_EXP_BITS_EN
    logic [1:0]  je1;
    logic [1:0]  je2;
`endif

    logic [7:0]  dout [2];
    logic        dv   [2];
    logic        hit  [2];
    logic [2:0]  jo   [2];
    logic        c1   [2];
    logic        c2   [2];

    int tests = 0;
    int fails = 0;

    nes_joypad_port #(.CLK_PULSE_CYCLES(2), .OPEN_BUS_VALUE(OPEN)) dut_a (
        .clock(clock), .reset(rst[0]), .addr(addr), .dataIn(din), .rw(rw),
        .cpuValid(cv), .dataOut(dout[0]), .dataOutValid(dv[0]), .joyHit(hit[0]),
        .joyOut(jo[0]), .joyClk1(c1[0]), .joyClk2(c2[0]),
        .joyData1(jd1), .joyData2(jd2)
`ifdef JOYPAD_EXP_BITS_EN
        , .joyExp1(je1), .joyExp2(je2)
`endif
    );

    nes_joypad_port #(.CLK_PULSE_CYCLES(4), .OPEN_BUS_VALUE(OPEN)) dut_b (
        .clock(clock), .reset(rst[1]), .addr(addr), .dataIn(din), .rw(rw),
        .cpuValid(cv), .dataOut(dout[1]), .dataOutValid(dv[1]), .joyHit(hit[1]),
        .joyOut(jo[1]), .joyClk1(c1[1]), .joyClk2(c2[1]),
        .joyData1(jd1), .joyData2(jd2)
`ifdef JOYPAD_EXP_BITS_EN
        , .joyExp1(je1), .joyExp2(je2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pulse_len(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    // Reference model: timestamps of the last read per port and of the last
    // reset; a clock line is high for exactly pulse_len edges after a read.
    int          t = 0;
    int          last_read [2][2];
    int          last_rst  [2];
    bit          known     [2];
    logic [7:0]  e_dout    [2];
    logic        e_dv      [2];
    logic [2:0]  e_jo      [2];

    always begin : monitor
        logic [15:0] s_a;
        logic [7:0]  s_d;
        logic        s_v, s_r, s_j1, s_j2;
        logic [1:0]  s_rst, s_e1, s_e2, ebits;
        logic        rd1, rd2, wr, e_hit, e_c1, e_c2;
        @(posedge clock);
        s_a = addr; s_d = din; s_v = cv; s_r = rw; s_j1 = jd1; s_j2 = jd2; s_rst = rst;
`ifdef JOYPAD_EXP_BITS_EN
        s_e1 = je1; s_e2 = je2;
`else
        s_e1 = 2'b11; s_e2 = 2'b11;
`endif
        rd1 = s_v && s_r && (s_a == 16'h4016);
        rd2 = s_v && s_r && (s_a == 16'h4017);
        wr  = s_v && !s_r && (s_a == 16'h4016);
        e_hit = s_v && ((s_a == 16'h4016) || (s_r && (s_a == 16'h4017)));
`ifdef JOYPAD_EXP_BITS_EN
        ebits = rd1 ? ~s_e1 : ~s_e2;
`else
        ebits = 2'b00;
`endif
        t++;
        for (int k = 0; k < 2; k++) begin
            if (s_rst[k]) begin
                known[k]    = 1'b1;
                last_rst[k] = t;
                e_dout[k]   = OPEN;
                e_dv[k]     = 1'b0;
                e_jo[k]     = 3'b000;
            end else begin
                e_dv[k] = rd1 || rd2;
                if (rd1) last_read[k][0] = t;
                if (rd2) last_read[k][1] = t;
                if (rd1 || rd2)
                    e_dout[k] = {OPEN[7:5], ebits, 2'b00, rd1 ? ~s_j1 : ~s_j2};
                if (wr) e_jo[k] = s_d[2:0];
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d joyHit", k), 32'(hit[k]), 32'(e_hit));
            if (known[k]) begin
                e_c1 = (last_read[k][0] > last_rst[k]) && (t - last_read[k][0] < pulse_len(k));
                e_c2 = (last_read[k][1] > last_rst[k]) && (t - last_read[k][1] < pulse_len(k));
                check($sformatf("dut%0d dataOut", k),      32'(dout[k]), 32'(e_dout[k]));
                check($sformatf("dut%0d dataOutValid", k), 32'(dv[k]),   32'(e_dv[k]));
                check($sformatf("dut%0d joyOut", k),       32'(jo[k]),   32'(e_jo[k]));
                check($sformatf("dut%0d joyClk1", k),      32'(c1[k]),   32'(e_c1));
                check($sformatf("dut%0d joyClk2", k),      32'(c2[k]),   32'(e_c2));
            end
        end
    end

    task automatic drive(input logic v, input logic [15:0] a, input logic r, input logic [7:0] d,
                         input logic j1, input logic j2, input logic [1:0] rs);
        @(negedge clock);
        cv = v; addr = a; rw = r; din = d; jd1 = j1; jd2 = j2; rst = rs;
`ifdef JOYPAD_EXP_BITS_EN
        je1 = 2'($urandom); je2 = 2'($urandom);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b1, 2'b00);
    endtask

    bit prev2 [2];
    int rise2 [2];

    task automatic tick();
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            if ((c2[k] === 1'b1) && !prev2[k]) rise2[k]++;
            prev2[k] = (c2[k] === 1'b1);
        end
    endtask

    initial begin : stim
        logic [7:0] pat;
        logic [7:0] got;
        logic [4:0] v1, v2, vv;
        int hc;
        for (int k = 0; k < 2; k++) begin
            last_read[k][0] = -1000; last_read[k][1] = -1000;
            last_rst[k] = 0; known[k] = 1'b0;
        end
        rst = 2'b11; cv = 1'b0; addr = 16'h0; rw = 1'b1; din = 8'h0; jd1 = 1'b1; jd2 = 1'b1;
`ifdef JOYPAD_EXP_BITS_EN
        je1 = 2'b11; je2 = 2'b11;
`endif
        drive(1'b0, 16'h0, 1'b1, 8'h0, 1'b1, 1'b1, 2'b11);
        tick();
        check("reset dataOut", 32'(dout[0]), 32'h40);
        check("reset dataOutValid", 32'(dv[0]), 32'h0);
        check("reset joyOut", 32'(jo[0]), 32'h0);
        check("reset joyClk", 32'({c1[0], c2[0], c1[1], c2[1]}), 32'h0);
        idle(3);

        // OUT latch write and ignored $4017 write
        drive(1'b1, 16'h4016, 1'b0, 8'hFD, 1'b1, 1'b1, 2'b00);
        tick();
        check("write joyOut", 32'(jo[0]), 32'h5);
        check("write no valid", 32'(dv[0]), 32'h0);
        drive(1'b1, 16'h4017, 1'b0, 8'h07, 1'b1, 1'b1, 2'b00);
        #1;
        check("write 4017 joyHit", 32'(hit[0]), 32'h0);
        tick();
        check("write 4017 joyOut", 32'(jo[0]), 32'h5);
        idle(3);

        // Single port 1 read, pressed button
        drive(1'b1, 16'h4016, 1'b1, 8'h00, 1'b0, 1'b1, 2'b00);
        tick();
        check("read dataOut", 32'(dout[0]), 32'h41);
        check("read valid", 32'(dv[0]), 32'h1);
        check("read joyClk1 N+1", 32'(c1[0]), 32'h1);
        check("read joyClk2 quiet", 32'(c2[0]), 32'h0);
        idle(1);
        tick();
        check("read joyClk1 N+2", 32'(c1[0]), 32'h1);
        check("read dataOut hold", 32'(dout[0]), 32'h41);
        idle(1);
        tick();
        check("read joyClk1 N+3", 32'(c1[0]), 32'h0);
        idle(6);

        // 8-bit shift-out on port 2, reads 4 cycles apart
        pat = 8'b10110010;
        got = 8'h00;
        for (int k = 0; k < 2; k++) begin rise2[k] = 0; prev2[k] = (c2[k] === 1'b1); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h4017, 1'b1, 8'h00, 1'b1, ~pat[i], 2'b00);
            tick();
            got[i] = dout[0][0];
            for (int j = 0; j < 3; j++) begin
                idle(1);
                tick();
            end
        end
        check("readout bits", 32'(got), 32'hB2);
        check("readout edges w2", 32'(rise2[0]), 32'd8);
        check("readout edges w4", 32'(rise2[1]), 32'd1);
        idle(6);

        // Back-to-back port 1 reads then a port 2 read
        drive(1'b1, 16'h4016, 1'b1, 8'h00, 1'b1, 1'b1, 2'b00);
        tick(); v1[0] = c1[0]; v2[0] = c2[0]; vv[0] = dv[0];
        drive(1'b1, 16'h4016, 1'b1, 8'h00, 1'b0, 1'b1, 2'b00);
        tick(); v1[1] = c1[0]; v2[1] = c2[0]; vv[1] = dv[0];
        drive(1'b1, 16'h4017, 1'b1, 8'h00, 1'b1, 1'b0, 2'b00);
        tick(); v1[2] = c1[0]; v2[2] = c2[0]; vv[2] = dv[0];
        idle(1);
        tick(); v1[3] = c1[0]; v2[3] = c2[0]; vv[3] = dv[0];
        idle(1);
        tick(); v1[4] = c1[0]; v2[4] = c2[0]; vv[4] = dv[0];
        check("b2b joyClk1", 32'(v1), 32'h07);
        check("b2b joyClk2", 32'(v2), 32'h0C);
        check("b2b valid", 32'(vv), 32'h07);
        idle(6);

        // Reset mid-pulse on the 4-cycle instance
        drive(1'b1, 16'h4017, 1'b1, 8'h00, 1'b1, 1'b1, 2'b00);
        idle(1);
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b1, 2'b10);
        tick();
        check("midreset joyClk2", 32'(c2[1]), 32'h0);
        idle(2);
        drive(1'b1, 16'h4017, 1'b1, 8'h00, 1'b1, 1'b1, 2'b00);
        hc = 0;
        for (int k = 0; k < 2; k++) rise2[k] = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            hc += (c2[1] === 1'b1) ? 1 : 0;
            idle(1);
        end
        check("post-reset pulse width", 32'(hc), 32'd4);
        check("post-reset edges", 32'(rise2[1]), 32'd1);

        // Randomized traffic with occasional independent resets
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            case ($urandom_range(0, 5))
                0, 1:    a = 16'h4016;
                2, 3:    a = 16'h4017;
                4:       a = 16'h4000 + 16'($urandom_range(0, 31));
                default: a = 16'($urandom);
            endcase
            drive(1'($urandom), a, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  {($urandom_range(0, 199) == 0), ($urandom_range(0, 199) == 0)});
        end
        idle(8);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
